// File: rtl/mania_pkg.sv
// Lane constants and the event type shared by the rhythm-game input path.
package mania_pkg;

    localparam int DEFAULT_TIME_W = 16;
    localparam int NUM_LANES      = 4;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE_A = 2'd0;
    localparam lane_t LANE_S = 2'd1;
    localparam lane_t LANE_K = 2'd2;
    localparam lane_t LANE_L = 2'd3;

    // 'time' is a reserved word, so the timestamp field is called stamp.
    typedef struct packed {
        lane_t                     lane;
        logic                      press;
        logic [DEFAULT_TIME_W-1:0] stamp;
    } lane_evt_t;

endpackage

// File: rtl/lane_event_arbiter_if.sv
// Valid/ready event stream from the lane arbiter to the note judge.
interface lane_event_arbiter_if
    import mania_pkg::*;
#(
    parameter int TIME_W = DEFAULT_TIME_W
);
    logic              evt_valid;
    logic              evt_ready;
    lane_t             evt_lane;
    logic              evt_press;
    logic [TIME_W-1:0] evt_time;

    modport master (
        output evt_valid,
        output evt_lane,
        output evt_press,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_lane,
        input  evt_press,
        input  evt_time,
        output evt_ready
    );
endinterface

// File: rtl/lane_event_arbiter_edge_slot.sv
// Per-lane input path: optional debounce (KEY_DEBOUNCE_EN), edge detect, one-deep
// pending event slot and sticky overflow flag.
`ifdef KEY_DEBOUNCE_EN
module key_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);
    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // The level flips on the cycle the raw input has disagreed for the full window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (raw_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = raw_i;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule
`endif

module lane_edge_slot
    import mania_pkg::*;
#(
    parameter int TIME_W = DEFAULT_TIME_W
`ifdef KEY_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 1000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_i,
    input  logic [TIME_W-1:0] song_time_i,
    input  logic              grant_i,
    input  logic              clr_drop_i,
    output logic              slot_valid_o,
    output logic [TIME_W:0]   slot_data_o,
    output logic              drop_o
);
    logic            level;
    logic            prev_q;
    logic            key_edge;
    logic            slot_valid_q, slot_valid_d;
    logic [TIME_W:0] slot_data_q, slot_data_d;
    logic            drop_q, drop_d;

`ifdef KEY_DEBOUNCE_EN
    key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (key_i),
        .level_o (level)
    );
`else
    assign level = key_i;
`endif

    assign key_edge = level ^ prev_q;

    // A slot being granted this cycle counts as empty, so a new edge reloads it.
    always_comb begin
        slot_valid_d = slot_valid_q & ~grant_i;
        slot_data_d  = slot_data_q;
        drop_d       = drop_q & ~clr_drop_i;
        if (key_edge) begin
            if (slot_valid_d) begin
                drop_d = 1'b1;
            end else begin
                slot_valid_d = 1'b1;
                slot_data_d  = {level, song_time_i};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_data_q  <= '0;
            drop_q       <= 1'b0;
        end else begin
            prev_q       <= level;
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            drop_q       <= drop_d;
        end
    end

    assign slot_valid_o = slot_valid_q;
    assign slot_data_o  = slot_data_q;
    assign drop_o       = drop_q;
endmodule

// File: rtl/lane_event_arbiter.sv
// Four-lane key event timestamping and round-robin serialisation onto a valid/ready
// stream, plus enter start pulse. Build macro KEY_DEBOUNCE_EN adds input debouncing.
module lane_event_arbiter
    import mania_pkg::*;
#(
    parameter int          TIME_W          = DEFAULT_TIME_W,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_a,
    input  logic                        key_s,
    input  logic                        key_k,
    input  logic                        key_l,
    input  logic                        key_enter,
    input  logic [TIME_W-1:0]           song_time,
    lane_event_arbiter_if.master        evt,
    output logic                        start_pulse,
    output logic [NUM_LANES-1:0]        drop_flags,
    input  logic                        clr_drop
);
    logic [NUM_LANES-1:0] keys;
    logic [NUM_LANES-1:0] slot_valid;
    logic [NUM_LANES-1:0] grant;
    logic [TIME_W:0]      slot_data [NUM_LANES];

    logic              out_valid_q, out_valid_d;
    lane_t             out_lane_q, out_lane_d;
    logic              out_press_q, out_press_d;
    logic [TIME_W-1:0] out_time_q, out_time_d;
    lane_t             rr_q, rr_d;

    logic  out_free;
    logic  gnt_found;
    lane_t gnt_lane;
    lane_t cand;

    logic enter_lvl;
    logic enter_prev_q;
    logic start_q;

    assign keys[LANE_A] = key_a;
    assign keys[LANE_S] = key_s;
    assign keys[LANE_K] = key_k;
    assign keys[LANE_L] = key_l;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_edge_slot #(
            .TIME_W          (TIME_W)
`ifdef KEY_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .key_i        (keys[g]),
            .song_time_i  (song_time),
            .grant_i      (grant[g]),
            .clr_drop_i   (clr_drop),
            .slot_valid_o (slot_valid[g]),
            .slot_data_o  (slot_data[g]),
            .drop_o       (drop_flags[g])
        );
    end

    assign out_free = ~out_valid_q | evt.evt_ready;

    // Round-robin search begins one past the last granted lane and ends on it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_lane  = rr_q;
        cand      = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = rr_q + lane_t'(i);
            if (!gnt_found && slot_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_lane  = cand;
            end
        end
        grant = '0;
        if (out_free && gnt_found) begin
            grant[gnt_lane] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_lane_d  = out_lane_q;
        out_press_d = out_press_q;
        out_time_d  = out_time_q;
        rr_d        = rr_q;
        if (out_free) begin
            out_valid_d = gnt_found;
            if (gnt_found) begin
                out_lane_d  = gnt_lane;
                out_press_d = slot_data[gnt_lane][TIME_W];
                out_time_d  = slot_data[gnt_lane][TIME_W-1:0];
                rr_d        = gnt_lane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_press_q <= 1'b0;
            out_time_q  <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_press_q <= out_press_d;
            out_time_q  <= out_time_d;
            rr_q        <= rr_d;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_filter (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (key_enter),
        .level_o (enter_lvl)
    );
`else
    assign enter_lvl = key_enter;
`endif

    // Enter bypasses the event path entirely; it only produces the start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enter_prev_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            enter_prev_q <= enter_lvl;
            start_q      <= enter_lvl & ~enter_prev_q;
        end
    end

    assign start_pulse   = start_q;
    assign evt.evt_valid = out_valid_q;
    assign evt.evt_lane  = out_lane_q;
    assign evt.evt_press = out_press_q;
    assign evt.evt_time  = out_time_q;
endmodule
